dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate L1 data cache controller.
- Sits between the CPU MEM stage (32-bit load/store port) and `Data_Memory` (256-bit block port, enable/ack handshake).
- Hits complete in the request cycle. Misses stall the pipeline while a dirty victim is written back and the block is refilled.
- Instantiated inside `CPU` as `dcache`.

---
 rtl/dcache_pkg.sv | 18 +
 rtl/dcache_sram.sv | 24 ++
 rtl/dcache_ctrl.sv | 140 ++++++++++++++
 tb/tb_dcache_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared state encoding, address split and tag-entry layout for the L1 data cache
package dcache_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        MISS       = 3'd1,
        READMISS   = 3'd2,
        READMISSOK = 3'd3,
        WRITEBACK  = 3'd4
    } state_t;

    localparam int TAG_W = 22;
    localparam int IDX_W = 5;
    localparam int OFF_W = 5;
    localparam int VALID = 23;
    localparam int DIRTY = 22;

endpackage

// File: rtl/dcache_sram.sv
// rtl/dcache_sram.sv - single-port storage array, synchronous write and combinational read
module dcache_sram #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] memory [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            memory[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = memory[addr_i];

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate L1 data cache controller
// Hits complete in the request cycle; misses stall through optional write-back and refill.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES   = 32,
    parameter int BLOCK_W = 256,
    parameter int TAG_W   = 22
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [31:0]        p1_addr_i,
    input  logic [31:0]        p1_data_i,
    input  logic               p1_MemRead_i,
    input  logic               p1_MemWrite_i,
    output logic [31:0]        p1_data_o,
    output logic               p1_stall_o,
    input  logic [BLOCK_W-1:0] mem_data_i,
    input  logic               mem_ack_i,
    output logic [BLOCK_W-1:0] mem_data_o,
    output logic [31:0]        mem_addr_o,
    output logic               mem_enable_o,
    output logic               mem_write_o
);

    localparam int EW = TAG_W + 2;

    logic [IDX_W-1:0]   idx;
    logic [OFF_W-3:0]   wsel;
    logic [TAG_W-1:0]   addr_tag;
    logic [EW-1:0]      tag_entry;
    logic [EW-1:0]      tag_wdata;
    logic [BLOCK_W-1:0] line;
    logic [BLOCK_W-1:0] line_wdata;
    logic [BLOCK_W-1:0] merged;
    logic               sram_valid;
    logic               sram_dirty;
    logic               hit;
    logic               req;
    logic               fill_we;
    logic               store_we;
    logic               sram_we;
    state_t             state;
    logic               mem_enable_q;
    logic               mem_write_q;
    logic [31:0]        mem_addr_q;
    logic [BLOCK_W-1:0] mem_data_q;
    wire                unused_addr_lsb = ^p1_addr_i[1:0];

    assign idx        = p1_addr_i[OFF_W +: IDX_W];
    assign wsel       = p1_addr_i[2 +: OFF_W-2];
    assign addr_tag   = p1_addr_i[31 -: TAG_W];
    assign sram_valid = tag_entry[VALID];
    assign sram_dirty = tag_entry[DIRTY];
    assign hit        = sram_valid && (tag_entry[TAG_W-1:0] == addr_tag);
    assign req        = p1_MemRead_i || p1_MemWrite_i;

    assign p1_stall_o = (state != IDLE) || (req && !hit);
    assign p1_data_o  = (p1_MemRead_i && !p1_MemWrite_i && hit) ? line[{wsel, 5'd0} +: 32] : 32'd0;

    always_comb begin
        merged = line;
        merged[{wsel, 5'd0} +: 32] = p1_data_i;
    end

    // Refill and store merge never coincide: they are qualified by disjoint states.
    assign fill_we    = (state == READMISS) && mem_ack_i;
    assign store_we   = p1_MemWrite_i && hit && ((state == IDLE) || (state == READMISSOK));
    assign sram_we    = rst_i && (fill_we || store_we);
    assign tag_wdata  = {1'b1, !fill_we, addr_tag};
    assign line_wdata = fill_we ? mem_data_i : merged;

    dcache_sram #(.WIDTH(EW), .DEPTH(LINES)) dcache_tag_sram (
        .clk_i   (clk_i),
        .we_i    (sram_we),
        .addr_i  (idx),
        .wdata_i (tag_wdata),
        .rdata_o (tag_entry)
    );

    dcache_sram #(.WIDTH(BLOCK_W), .DEPTH(LINES)) dcache_data_sram (
        .clk_i   (clk_i),
        .we_i    (sram_we),
        .addr_i  (idx),
        .wdata_i (line_wdata),
        .rdata_o (line)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && !hit) begin
                        state <= MISS;
                    end
                end
                MISS: begin
                    mem_enable_q <= 1'b1;
                    if (sram_dirty) begin
                        state       <= WRITEBACK;
                        mem_write_q <= 1'b1;
                        mem_addr_q  <= {tag_entry[TAG_W-1:0], idx, {OFF_W{1'b0}}};
                        mem_data_q  <= line;
                    end else begin
                        state       <= READMISS;
                        mem_write_q <= 1'b0;
                        mem_addr_q  <= {addr_tag, idx, {OFF_W{1'b0}}};
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        state       <= READMISS;
                        mem_write_q <= 1'b0;
                        mem_addr_q  <= {addr_tag, idx, {OFF_W{1'b0}}};
                    end
                end
                READMISS: begin
                    if (mem_ack_i) begin
                        state        <= READMISSOK;
                        mem_enable_q <= 1'b0;
                    end
                end
                READMISSOK: state <= IDLE;
                default:    state <= IDLE;
            endcase
        end
    end

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - self-checking bench for dcache_ctrl against a flat word-memory reference
module tb_dcache_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  p1_addr;
    logic [31:0]  p1_wdata;
    logic         p1_rd;
    logic         p1_wr;
    logic [31:0]  p1_rdata;
    logic         p1_stall;
    logic [255:0] mem_rdata;
    logic         mem_ack;
    logic [255:0] mem_wdata;
    logic [31:0]  mem_addr;
    logic         mem_en;
    logic         mem_we;

    int total = 0;
    int bad   = 0;

    // Architectural view: last value stored per word address, and memory-side block contents.
    logic [31:0]  fm   [logic [31:0]];
    logic [255:0] bmem [logic [31:0]];
    // Which block each line holds, and whether it has been stored to since refill.
    bit           rv   [32];
    bit           rdty [32];
    logic [21:0]  rt   [32];

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .p1_addr_i     (p1_addr),
        .p1_data_i     (p1_wdata),
        .p1_MemRead_i  (p1_rd),
        .p1_MemWrite_i (p1_wr),
        .p1_data_o     (p1_rdata),
        .p1_stall_o    (p1_stall),
        .mem_data_i    (mem_rdata),
        .mem_ack_i     (mem_ack),
        .mem_data_o    (mem_wdata),
        .mem_addr_o    (mem_addr),
        .mem_enable_o  (mem_en),
        .mem_write_o   (mem_we)
    );

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a[31:5] == 27'd0) return (a == 32'd0) ? 32'd5 : 32'd0;
        return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
    endfunction

    function automatic logic [31:0] flat_rd(input logic [31:0] a);
        if (fm.exists(a)) return fm[a];
        return init_word(a);
    endfunction

    function automatic logic [255:0] flat_block(input logic [31:0] b);
        logic [255:0] blk;
        for (int k = 0; k < 8; k++) blk[k*32 +: 32] = flat_rd(b + 32'(4 * k));
        return blk;
    endfunction

    function automatic logic [255:0] mem_block(input logic [31:0] b);
        logic [255:0] blk;
        if (bmem.exists(b)) return bmem[b];
        for (int k = 0; k < 8; k++) blk[k*32 +: 32] = init_word(b + 32'(4 * k));
        return blk;
    endfunction

    // One CPU access; the bench plays the memory with a fixed ack latency per request.
    task automatic access(input logic [31:0] a, input logic w, input logic [31:0] wd, input int lat);
        logic [4:0]  idx;
        logic [21:0] tg;
        logic        exp_hit;
        logic        exp_victim;
        logic [31:0] victim_addr;
        logic [31:0] held_addr;
        logic        held_we;
        int          exp_stall;
        int          stalls;
        int          en_cnt;
        int          nreq;
        idx         = a[9:5];
        tg          = a[31:10];
        exp_hit     = rv[idx] && (rt[idx] == tg);
        exp_victim  = !exp_hit && rv[idx] && rdty[idx];
        victim_addr = {rt[idx], idx, 5'd0};
        exp_stall   = exp_hit ? 0 : (exp_victim ? 2 * lat + 3 : lat + 3);
        held_addr   = '0;
        held_we     = 1'b0;
        @(negedge clk);
        p1_addr  = a;
        p1_wdata = wd;
        p1_wr    = w;
        p1_rd    = !w;
        stalls   = 0;
        en_cnt   = 0;
        nreq     = 0;
        #1;
        while (p1_stall === 1'b1 && stalls < 200) begin
            stalls++;
            mem_ack = 1'b0;
            if (mem_en === 1'b1) begin
                en_cnt++;
                if (en_cnt == 1) begin
                    nreq++;
                    held_addr = mem_addr;
                    held_we   = mem_we;
                end else begin
                    check("req_hold", {mem_we, mem_addr}, {held_we, held_addr});
                end
                if (en_cnt == lat) begin
                    mem_ack = 1'b1;
                    en_cnt  = 0;
                    if (mem_we === 1'b1) begin
                        check("wb_addr", mem_addr, victim_addr);
                        check("wb_data", mem_wdata, flat_block(victim_addr));
                        bmem[mem_addr] = mem_wdata;
                    end else begin
                        check("rd_addr", mem_addr, {tg, idx, 5'd0});
                        mem_rdata = mem_block(mem_addr);
                    end
                end
            end
            @(negedge clk);
            #1;
        end
        mem_ack = 1'b0;
        check("stall_cycles", stalls, exp_stall);
        check("mem_requests", nreq, exp_hit ? 0 : (exp_victim ? 2 : 1));
        if (!w) check("load_data", p1_rdata, flat_rd(a));
        if (!exp_hit) begin
            rv[idx]   = 1'b1;
            rt[idx]   = tg;
            rdty[idx] = 1'b0;
        end
        if (w) begin
            rdty[idx] = 1'b1;
            fm[a]     = wd;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        p1_rd = 1'b0;
        p1_wr = 1'b0;
        #1;
        check("idle_stall", p1_stall, 1'b0);
        check("idle_data", p1_rdata, 32'd0);
        check("idle_enable", mem_en, 1'b0);
    endtask

    initial begin
        logic [23:0] tag_before;
        logic [31:0] ra;
        int          n;
        rst_n     = 1'b0;
        p1_addr   = '0;
        p1_wdata  = '0;
        p1_rd     = 1'b0;
        p1_wr     = 1'b0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        for (int i = 0; i < 32; i++) begin
            dut.dcache_tag_sram.memory[i]  = '0;
            dut.dcache_data_sram.memory[i] = '0;
            rv[i]   = 1'b0;
            rdty[i] = 1'b0;
            rt[i]   = '0;
        end
        #1;
        check("rst_state", dut.state, 3'd0);
        check("rst_enable", mem_en, 1'b0);
        check("rst_write", mem_we, 1'b0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_mdata", mem_wdata, 256'd0);
        check("rst_stall", p1_stall, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        access(32'h0000_0000, 1'b0, 32'd0, 10);
        check("cold_tag0", dut.dcache_tag_sram.memory[0], 24'h800000);

        access(32'h0000_0004, 1'b0, 32'd0, 3);

        access(32'h0000_0008, 1'b1, 32'h0000_1234, 3);
        @(posedge clk);
        #1;
        check("store_word", dut.dcache_data_sram.memory[0][95:64], 32'h0000_1234);
        check("store_dirty", dut.sram_dirty, 1'b1);

        access(32'h0000_0400, 1'b0, 32'd0, 4);
        check("refill_tag0", dut.dcache_tag_sram.memory[0], 24'h800001);
        check("wb_word2", bmem[32'h0][95:64], 32'h0000_1234);

        access(32'h0000_0020, 1'b1, 32'h0000_CAFE, 3);
        @(posedge clk);
        #1;
        check("stmiss_dirty", dut.dcache_tag_sram.memory[1][22], 1'b1);
        check("stmiss_word", dut.dcache_data_sram.memory[1][31:0], 32'h0000_CAFE);

        tag_before = dut.dcache_tag_sram.memory[2];
        @(negedge clk);
        p1_addr = 32'h0000_0840;
        p1_rd   = 1'b1;
        p1_wr   = 1'b0;
        n = 0;
        while (dut.state !== 3'd2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reach_readmiss", (n < 20), 1'b1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        p1_rd = 1'b0;
        #1;
        check("rstmid_state", dut.state, 3'd0);
        check("rstmid_enable", mem_en, 1'b0);
        check("rstmid_tag", dut.dcache_tag_sram.memory[2], tag_before);
        @(negedge clk);
        rst_n = 1'b1;
        access(32'h0000_0840, 1'b0, 32'd0, 2);

        for (int t = 0; t < 150; t++) begin
            ra = {22'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00};
            if ($urandom_range(0, 3) == 0) idle();
            access(ra, 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(1, 5)));
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
